// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline with multu sequencing.
// Define HAZ_STATS_EN to build the stall/flush statistics counters.
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_multu,
   input  logic        id_mfhilo,
   input  logic        ex_memread,
   input  logic [4:0]  ex_wn,
   input  logic        branch_taken,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_bubble,
   output logic        mult_start,
   output logic        mult_abort,
   output logic        mult_busy,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
);

   typedef enum logic {IDLE, MULT_RUN} state_t;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             busy_n;
   logic             lu, mh, stall;

   assign lu    = ex_memread && (ex_wn != 5'd0) &&
                  ((ex_wn == id_rs) || (id_uses_rt && (ex_wn == id_rt)));
   assign mh    = mult_busy && (id_mfhilo || id_multu);
   assign stall = (lu || mh) && !branch_taken;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_bubble = 1'b0;
      if (branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      busy_n     = mult_busy;
      mult_start = 1'b0;
      mult_abort = 1'b0;
      unique case (state)
         IDLE: begin
            mult_start = id_multu && !lu && !branch_taken && !rst;
            if (mult_start) begin
               state_n = MULT_RUN;
               cnt_n   = CNT_INIT;
               busy_n  = 1'b1;
            end
         end
         MULT_RUN: begin
            // A branch resolving in the first run cycle is older than the multu.
            if (branch_taken && (cnt == CNT_INIT)) begin
               mult_abort = !rst;
               state_n    = IDLE;
               cnt_n      = '0;
               busy_n     = 1'b0;
            end else if (cnt == '0) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         mult_busy <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         mult_busy <= busy_n;
      end
   end

`ifdef HAZ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 16'd1;
         if (branch_taken && (flush_count != '1))
            flush_count <= flush_count + 16'd1;
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

   localparam int MC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_wn;
   logic        id_uses_rt, id_multu, id_mfhilo, ex_memread, branch_taken;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
   logic        mult_start, mult_abort, mult_busy;
   logic [15:0] stall_cycles, flush_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: remaining busy cycles of the multiplier and stat totals.
   int rem       = 0;
   int m_stalls  = 0;
   int m_flushes = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MULT_CYCLES(MC), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_multu(id_multu), .id_mfhilo(id_mfhilo),
      .ex_memread(ex_memread), .ex_wn(ex_wn), .branch_taken(branch_taken),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_bubble(idex_bubble),
      .mult_start(mult_start), .mult_abort(mult_abort), .mult_busy(mult_busy),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mu, input logic mf,
                       input logic mr, input logic [4:0] wn, input logic bt);
      logic lu, busy, stl, e_start, e_abort;
      rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_multu = mu;
      id_mfhilo = mf; ex_memread = mr; ex_wn = wn; branch_taken = bt;
      #1;
      lu      = mr && (wn != 0) && ((wn == rs) || (urt && (wn == rt)));
      busy    = (rem > 0);
      stl     = (lu || (busy && (mf || mu))) && !bt;
      e_start = !busy && mu && !lu && !bt && !r;
      e_abort = (rem == MC) && bt && !r;
      check("pc_en",       32'(pc_en),       32'(bt || !stl));
      check("ifid_en",     32'(ifid_en),     32'(bt || !stl));
      check("ifid_flush",  32'(ifid_flush),  32'(bt));
      check("idex_en",     32'(idex_en),     32'd1);
      check("idex_bubble", 32'(idex_bubble), 32'(bt || stl));
      check("mult_start",  32'(mult_start),  32'(e_start));
      check("mult_abort",  32'(mult_abort),  32'(e_abort));
      check("mult_busy",   32'(mult_busy),   32'(busy));
`ifdef HAZ_STATS_EN
      check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
      check("flush_count",  32'(flush_count),  32'(m_flushes));
`else
      check("stall_cycles", 32'(stall_cycles), 32'd0);
      check("flush_count",  32'(flush_count),  32'd0);
`endif
      @(posedge clk);
      if (r) begin
         rem = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (busy) rem = e_abort ? 0 : rem - 1;
         else if (e_start) rem = MC;
         if (stl && m_stalls < 65535) m_stalls++;
         if (bt && m_flushes < 65535) m_flushes++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 0; id_multu = 0;
      id_mfhilo = 0; ex_memread = 0; ex_wn = '0; branch_taken = 0;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // load-use on rs, then negatives
      step(0, 5, 0, 0, 0, 0, 1, 5, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 7, 0, 0, 0, 1, 7, 0);
      step(0, 1, 7, 1, 0, 0, 1, 7, 0);

      // multu then mfhi held until release
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle(1);

      // abort in first run cycle
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);

      // late branch does not kill the multiply; back-to-back multu
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(4);

      // flush beats load-use; lu blocks multu start
      step(0, 3, 0, 0, 0, 0, 1, 3, 1);
      step(0, 3, 0, 0, 1, 0, 1, 3, 0);
      step(0, 3, 0, 0, 1, 0, 0, 3, 0);
      idle(5);

      // reset mid-multiply
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // statistics: 3 load-use stalls, 2 flushes
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 9, 0, 0, 0, 0, 1, 9, 0);
         idle(1);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef HAZ_STATS_EN
      check("stats_stalls_3",  32'(stall_cycles), 32'd3);
      check("stats_flushes_2", 32'(flush_count),  32'd2);
`else
      check("stats_stalls_off",  32'(stall_cycles), 32'd0);
      check("stats_flushes_off", 32'(flush_count),  32'd0);
`endif

      // randomized traffic with narrow register ranges to force matches
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
